// File: rtl/sched_update_pkg.sv
// Shared types for the scheduled-update unit: per-slot state and the free-slot picker.
package sched_update_pkg;

  localparam int SU_DATA_W = 32;
  localparam int SU_DLY_W  = 8;
  localparam int SU_DEPTH  = 4;

  typedef struct packed {
    logic                 valid;
    logic [SU_DLY_W-1:0]  cnt;
    logic [SU_DATA_W-1:0] data;
  } slot_t;

  // One-hot of the lowest-index clear bit; all zeros when every slot is busy.
  function automatic logic [SU_DEPTH-1:0] lowest_free(input logic [SU_DEPTH-1:0] busy);
    return ~busy & (busy + SU_DEPTH'(1));
  endfunction

endpackage

// File: rtl/sched_update_slot.sv
// One pending-event slot: counts its delay down and flags maturity at zero.
// Registered state, mature is combinational from state; no backpressure (owner allocates only when free).
module sched_update_slot
  import sched_update_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_i,
  input  logic                 flush_i,
  input  logic [SU_DATA_W-1:0] data_i,
  input  logic [SU_DLY_W-1:0]  delay_i,
  output logic                 valid_o,
  output logic                 mature_o,
  output logic [SU_DATA_W-1:0] data_o
);

  slot_t slot_q, slot_d;

  assign valid_o  = slot_q.valid;
  assign mature_o = slot_q.valid && (slot_q.cnt == '0);
  assign data_o   = slot_q.data;

  always_comb begin
    slot_d = slot_q;
    if (flush_i || mature_o) begin
      slot_d.valid = 1'b0;
    end else if (slot_q.valid) begin
      slot_d.cnt = slot_q.cnt - SU_DLY_W'(1);
    end
    // Allocation only ever targets a slot that is free now, so it never races the clear above.
    if (alloc_i) begin
      slot_d.valid = 1'b1;
      slot_d.cnt   = delay_i;
      slot_d.data  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/sched_update_unit.sv
// Delayed-commit register: request (data, d) accepted at edge E lands in val_q at edge E+d+1, newest wins.
// req_ready drops while every slot is occupied; all outputs are registered.
module sched_update_unit
  import sched_update_pkg::*;
#(
  parameter int                DATA_W    = SU_DATA_W,
  parameter int                DLY_W     = SU_DLY_W,
  parameter int                DEPTH     = SU_DEPTH,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_W-1:0]          req_data,
  input  logic [DLY_W-1:0]           req_delay,
  input  logic                       flush,
  output logic [DATA_W-1:0]          val_q,
  output logic                       val_changed,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       full
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  busy, mature, alloc_oh, busy_nxt, newest;
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  age_q [DEPTH];
  logic [DEPTH-1:0]  age_d [DEPTH];
  logic              accept, commit;
  logic [DATA_W-1:0] commit_data, val_d;
  logic              changed_q, changed_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic              full_q, full_d;

  assign req_ready   = !full_q;
  assign accept      = req_valid && !full_q;
  assign alloc_oh    = accept ? lowest_free(busy) : '0;
  assign val_changed = changed_q;
  assign pending     = pending_q;
  assign full        = full_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    sched_update_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc_i  (alloc_oh[i]),
      .flush_i  (flush),
      .data_i   (req_data),
      .delay_i  (req_delay),
      .valid_o  (busy[i]),
      .mature_o (mature[i]),
      .data_o   (slot_data[i])
    );
  end

  // age_q[i][j] set means slot i was accepted after slot j.
  always_comb begin
    newest      = '0;
    commit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      newest[i] = mature[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && mature[j] && !age_q[i][j]) newest[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (newest[i]) commit_data = commit_data | slot_data[i];
    end
    commit    = (|mature) && !flush;
    val_d     = commit ? commit_data : val_q;
    changed_d = commit && (commit_data != val_q);
  end

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] && (mature[i] || flush)) begin
        age_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        age_d[i] = ~(DEPTH'(1) << i);
        for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
      end
    end
    busy_nxt  = flush ? alloc_oh : ((busy & ~mature) | alloc_oh);
    pending_d = CNT_W'($countones(busy_nxt));
    full_d    = &busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      val_q     <= RESET_VAL;
      changed_q <= 1'b0;
      pending_q <= '0;
      full_q    <= 1'b0;
    end else begin
      age_q     <= age_d;
      val_q     <= val_d;
      changed_q <= changed_d;
      pending_q <= pending_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: tb/tb_sched_update_unit.sv
// Directed bench for sched_update_unit: stimulus pushes expected commits (value, cycle) to a scoreboard,
// a negedge monitor pops one entry per val_changed pulse.
module tb_sched_update_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] req_data = '0;
  logic [7:0]  req_delay = '0;
  logic        req_ready, val_changed, full;
  logic [31:0] val_q;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  sched_update_unit #(
    .DATA_W(32), .DLY_W(8), .DEPTH(4), .RESET_VAL(32'd0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_delay   (req_delay),
    .flush       (flush),
    .val_q       (val_q),
    .val_changed (val_changed),
    .pending     (pending),
    .full        (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (rst_n && val_changed) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: val_changed=1 val_q=%0h at cycle %0d, expected no pulse", val_q, cyc);
      end else begin
        e = sb.pop_front();
        chk("commit_val", val_q, e.data);
        chk("commit_cycle", cyc, e.at);
      end
    end
  end

  // Called at a negedge with cycle C; accept edge is C+1, commit edge C+1+d+1.
  task automatic req(input logic [31:0] d, input logic [7:0] dl, input bit expect_pulse);
    req_valid = 1'b1;
    req_data  = d;
    req_delay = dl;
    if (expect_pulse) sb.push_back('{data: d, at: cyc + int'(dl) + 2});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", {val_q, val_changed, pending, req_ready, full}, {32'd0, 1'b0, 3'd0, 1'b1, 1'b0});
    idle(2);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_state", {val_q, val_changed, pending, req_ready, full}, {32'd0, 1'b0, 3'd0, 1'b1, 1'b0});
    end

    // single request
    req(32'd2, 8'd9, 1'b1);
    chk("single_pending_early", pending, 3'd1);
    idle(9);
    chk("single_pending_late", pending, 3'd1);
    chk("single_not_yet", val_q, 32'd0);
    idle(1);
    chk("single_val", val_q, 32'd2);
    chk("single_pending_done", pending, 3'd0);
    idle(3);

    // two requests maturing on the same edge: the later-accepted one wins
    req(32'd3, 8'd9, 1'b0);
    idle(4);
    req(32'd4, 8'd4, 1'b1);
    idle(4);
    chk("order_pending_two", pending, 3'd2);
    idle(1);
    chk("order_val", val_q, 32'd4);
    chk("order_pending_done", pending, 3'd0);
    idle(3);

    // fill all slots, then try to overfill
    c0 = cyc;
    for (int k = 0; k < 4; k++) req(32'd10 + 32'(k), 8'd50, 1'b1);
    chk("fill_full", full, 1'b1);
    chk("fill_ready", req_ready, 1'b0);
    chk("fill_pending", pending, 3'd4);
    req_valid = 1'b1;
    req_data  = 32'd99;
    req_delay = 8'd0;
    idle(5);
    req_valid = 1'b0;
    chk("fill_no_accept", pending, 3'd4);
    while (cyc < c0 + 51) @(negedge clk);
    chk("fill_ready_before_free", req_ready, 1'b0);
    @(negedge clk);
    chk("fill_ready_after_free", req_ready, 1'b1);
    chk("fill_full_after_free", full, 1'b0);
    chk("fill_pending_after_free", pending, 3'd3);
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    chk("fill_drained", sb.size(), 0);
    idle(1);
    chk("fill_last_val", val_q, 32'd13);

    // equal value commits without a pulse
    req(32'd7, 8'd0, 1'b1);
    idle(2);
    chk("equal_first", val_q, 32'd7);
    req(32'd7, 8'd0, 1'b0);
    idle(2);
    chk("equal_again", val_q, 32'd7);
    req(32'd8, 8'd0, 1'b1);
    idle(2);
    chk("equal_then_new", val_q, 32'd8);

    // flush with a simultaneous request
    req(32'd20, 8'd30, 1'b0);
    req(32'd21, 8'd30, 1'b0);
    req(32'd22, 8'd30, 1'b0);
    chk("flush_pending_before", pending, 3'd3);
    flush = 1'b1;
    req(32'd9, 8'd2, 1'b1);
    flush = 1'b0;
    chk("flush_pending_after", pending, 3'd1);
    idle(2);
    chk("flush_not_yet", val_q, 32'd8);
    idle(1);
    chk("flush_commit", val_q, 32'd9);
    chk("flush_pending_done", pending, 3'd0);

    // asynchronous reset while an event is pending
    req(32'd55, 8'd20, 1'b0);
    idle(5);
    chk("arst_pending_before", pending, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_val", val_q, 32'd0);
    chk("arst_pending", pending, 3'd0);
    chk("arst_ready", {req_ready, full}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    chk("arst_event_lost", val_q, 32'd0);
    chk("arst_pending_after", pending, 3'd0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sched_update_unit.md
# sched_update_unit

Scheduled-update unit: accepts write requests carrying a data value and a cycle delay, holds them as pending events, and commits each to a single output register when its delay expires. It is the consumer end of delayed-assignment semantics: the requester samples the value now, and this block applies it later with last-issued-wins ordering. It also raises a change-event pulse whenever the committed value actually changes. It sits between a request source (a sequencer or test driver) and logic that watches the committed value.

## Interface
- DATA_W, 32, width of data value
- DLY_W, 8, width of delay field (cycles)
- DEPTH, 4, number of pending-event slots (≥2)
- RESET_VAL, 0, reset value of val_q
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_data  in  DATA_W  value to commit
- req_delay  in  DLY_W  delay in cycles
- flush  in  1  discard all pending events
- val_q  out  DATA_W  committed value
- val_changed  out  1  one-cycle pulse when val_q took a different value
- pending  out  $clog2(DEPTH+1)  number of occupied slots
- full  out  1  all slots occupied

## Operation
- One clock domain, `clk`; reset is asynchronous and active-low, `rst_n`.
- Reset: all slots free, val_q=RESET_VAL, val_changed=0, pending=0, full=0, req_ready=1.
- Accept: req_valid && req_ready at edge E. The request goes into the lowest-index free slot, with cnt=req_delay and data=req_data. The slot becomes the newest in the age order.
- Each edge, per occupied slot: if cnt==0, the slot matures (commits candidate, slot freed); else cnt decrements.
- Commit: if ≥1 slot matures at an edge, val_q takes the data of the newest maturing slot (latest accepted). Older maturing slots are discarded.
- val_changed=1 for exactly the cycle in which val_q holds a new value different from its previous value. A commit of an equal value produces no pulse.
- Age order: DEPTH×DEPTH age matrix. On allocate, the new slot is marked newer than all occupied slots. Freed slots are cleared.
- flush: at that edge all slots are freed and no maturing slot commits. A request accepted at the same edge is stored after the clear and survives.
- req_ready = !full, evaluated from the current slot state. A slot freed at an edge is reusable from the next cycle (no same-edge reuse).
- pending and full are registered and reflect slot state after the edge.

## Timing
- A request accepted at edge E with delay d commits at edge E+d+1. val_q shows it in the cycle after that edge. Delay 0 gives one-cycle latency.
- Maximum latency is 2^DLY_W cycles; the delay field saturates by construction (no wrap).
- A request can never mature at its own accept edge.
- Throughput: one request per cycle while not full.
- Reset mid-operation: all pending events are lost immediately (asynchronously); val_q returns to RESET_VAL.
- val_changed is registered alongside val_q; there is no combinational path from req_* to the outputs.

## Structure
- Package sched_update_pkg holds:
  - slot_t struct: valid, cnt[DLY_W], data[DATA_W].
  - Helper function for the lowest-free-index priority encoder.
- Sub-module sched_update_slot (one instance per slot):
  - holds slot_t;
  - inputs alloc, flush, and the request fields;
  - outputs valid, mature, data.
- Top level holds:
  - the age matrix;
  - newest-mature selection;
  - val_q / val_changed registers;
  - the pending counter.

## Test plan
- Reset then idle: val_q=0, val_changed=0, pending=0, req_ready=1 for 20 cycles.
- Single request data=2, delay=9 at edge E: val_q=2 and val_changed=1 from edge E+10 for one cycle; pending=1 during the wait, then 0.
- Ordering: at E, data=3 delay=9; at E+5, data=4 delay=4. Both mature at E+10: val_q=4 (newest wins), a single val_changed pulse, pending=0 afterwards.
- Fill with DEPTH requests delay=50:
  - full=1, req_ready=0;
  - a further req_valid is not accepted;
  - the first maturity frees a slot and req_ready=1 the next cycle.
- Equal value: val_q=7, then commit 7 with delay=0 → no val_changed pulse. Then commit 8 → pulse.
- flush with 3 pending plus a simultaneous request (data=9, delay=2): pending=1 after the edge; only 9 commits, 3 edges later. Assert rst_n low mid-wait: val_q=0 and pending=0 immediately.
